// File: rtl/mcpu_pkg.sv
// Shared definitions for the mcpu run controller and core.
// State/reason encodings and instruction byte constants.
package mcpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSN_HALT   = 2'b00,
    RSN_LIMIT  = 2'b01,
    RSN_ABORT  = 2'b10,
    RSN_PC_OOR = 2'b11
  } reason_t;

  localparam logic [7:0] MCPU_NOP  = 8'h80;
  localparam logic [7:0] MCPU_HALT = 8'h00;

  localparam int MCPU_OP_IMM_BIT = 7;
  localparam int MCPU_OP_MSB     = 6;
  localparam int MCPU_OP_LSB     = 4;
  localparam int MCPU_ARG_MSB    = 3;
  localparam int MCPU_ARG_LSB    = 0;

endpackage

// File: rtl/mcpu_run_ctrl_if.sv
// Host program-load handshake for the run controller.
// Host is master; controller is slave.
interface mcpu_run_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;

  modport master (
    output ld_valid,
    output ld_addr,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_addr,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/mcpu_imem.sv
// Instruction byte memory: sync write, async read so the
// core sees the byte in the same cycle as its PC.
module mcpu_imem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mcpu_run_ctrl.sv
// Run controller: loads IMEM, runs the core, stops it on
// halt/limit/abort/PC out of range and reports why.
module mcpu_run_ctrl
  import mcpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int CYCLE_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mcpu_run_ctrl_if.slave        ld,
  input  logic                  i_cmd_start,
  input  logic                  i_cmd_abort,
  input  logic [CYCLE_W-1:0]    i_max_cycles,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_done_reason,
  output logic [CYCLE_W-1:0]    o_cycles_out,
  output logic                  o_core_reset,
  output logic [7:0]            o_core_irom,
  input  logic [DATA_WIDTH-1:0] i_core_pc
);

  state_t             r_state;
  state_t             w_next;
  reason_t            r_reason;
  reason_t            w_reason;
  logic [CYCLE_W-1:0] r_cycles;
  logic [CYCLE_W-1:0] r_limit;

  logic               w_run;
  logic               w_we;
  logic [7:0]         w_fetch;
  logic               w_oor;
  logic               w_halt;
  logic               w_lim;
  logic               w_stop;

  assign w_run = (r_state == ST_RUN);
  assign w_we  = ld.ld_valid & ld.ld_ready;

  mcpu_imem #(
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (ld.ld_addr),
    .i_wdata (ld.ld_data),
    .i_raddr (i_core_pc[ADDR_W-1:0]),
    .o_rdata (w_fetch)
  );

  assign w_oor  = i_core_pc >= DATA_WIDTH'(IMEM_DEPTH);
  assign w_halt = (w_fetch == MCPU_HALT);
  assign w_lim  = (r_limit != '0) && (r_cycles == r_limit);
  assign w_stop = w_run &
                  (i_cmd_abort | w_oor | w_halt | w_lim);

  // Overlapping causes: the first matching one wins.
  always_comb begin
    w_reason = RSN_LIMIT;
    if (i_cmd_abort) begin
      w_reason = RSN_ABORT;
    end else if (w_oor) begin
      w_reason = RSN_PC_OOR;
    end else if (w_halt) begin
      w_reason = RSN_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE,
      ST_DONE: begin
        if (i_cmd_start) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_stop) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles <= '0;
      r_limit  <= '0;
      r_reason <= RSN_HALT;
    end else if (!w_run) begin
      if (i_cmd_start) begin
        r_cycles <= '0;
        r_limit  <= i_max_cycles;
      end
    end else if (w_stop) begin
      r_reason <= w_reason;
    end else begin
      r_cycles <= r_cycles + CYCLE_W'(1);
    end
  end

  // Held in reset on the stopping cycle so it never executes.
  assign o_core_reset  = reset | ~w_run | w_stop;
  assign o_core_irom   = (w_run && !w_stop) ? w_fetch
                                            : MCPU_NOP;
  assign ld.ld_ready   = ~w_run;
  assign o_busy        = w_run;
  assign o_done        = (r_state == ST_DONE);
  assign o_done_reason = r_reason;
  assign o_cycles_out  = r_cycles;

endmodule
